// File: rtl/video_timing_generator.sv
// Raster timing generator: horizontal/vertical counters advanced by a pixel-rate
// enable, with a registered decode of sync, active video, pixel position,
// downscaled framebuffer address and line/frame start pulses.
module video_timing_generator #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0,
  parameter int   SCALE_SHIFT = 1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic pixel_en_i,
  output logic hsync_o,
  output logic vsync_o,
  output logic video_en_o,
  output logic [$clog2(H_ACTIVE)-1:0] x_o,
  output logic [$clog2(V_ACTIVE)-1:0] y_o,
  output logic [$clog2((H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT))-1:0] addr_o,
  output logic line_start_o,
  output logic frame_start_o
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W         = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H         = V_ACTIVE >> SCALE_SHIFT;
  localparam int ADDR_W       = $clog2(FB_W * FB_H);
  localparam int X_W          = $clog2(H_ACTIVE);
  localparam int Y_W          = $clog2(V_ACTIVE);
  localparam int HC_W         = $clog2(H_TOTAL);
  localparam int VC_W         = $clog2(V_TOTAL);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [HC_W-1:0]   h_cnt_q, h_cnt_d;
  logic [VC_W-1:0]   v_cnt_q, v_cnt_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              video_en_q, video_en_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;

  logic              h_last_s, v_last_s;
  logic              in_hsync_s, in_vsync_s, active_s;
  logic [ADDR_W-1:0] addr_s;

  // Decode of the raster position currently held in the counters.
  always_comb begin
    h_last_s   = (h_cnt_q == HC_W'(H_TOTAL - 1));
    v_last_s   = (v_cnt_q == VC_W'(V_TOTAL - 1));
    in_hsync_s = (h_cnt_q >= HC_W'(H_SYNC_START)) && (h_cnt_q < HC_W'(H_SYNC_END));
    in_vsync_s = (v_cnt_q >= VC_W'(V_SYNC_START)) && (v_cnt_q < VC_W'(V_SYNC_END));
    active_s   = (h_cnt_q < HC_W'(H_ACTIVE)) && (v_cnt_q < VC_W'(V_ACTIVE));
    // Only meaningful inside the active area, where it stays below FB_W*FB_H.
    addr_s     = ADDR_W'(v_cnt_q >> SCALE_SHIFT) * ADDR_W'(FB_W)
               + ADDR_W'(h_cnt_q >> SCALE_SHIFT);
  end

  // Counter advance and output loading; everything holds on disabled edges.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_en_d    = video_en_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pixel_en_i) begin
      if (h_last_s) begin
        h_cnt_d = {HC_W{1'b0}};
        if (v_last_s) begin
          v_cnt_d = {VC_W{1'b0}};
        end else begin
          v_cnt_d = v_cnt_q + VC_W'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HC_W'(1);
        v_cnt_d = v_cnt_q;
      end
      hsync_d       = in_hsync_s ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = in_vsync_s ? VSYNC_POL : ~VSYNC_POL;
      video_en_d    = active_s;
      x_d           = active_s ? X_W'(h_cnt_q) : {X_W{1'b0}};
      y_d           = active_s ? Y_W'(v_cnt_q) : {Y_W{1'b0}};
      addr_d        = active_s ? addr_s : {ADDR_W{1'b0}};
      line_start_d  = (h_cnt_q == {HC_W{1'b0}});
      frame_start_d = (h_cnt_q == {HC_W{1'b0}}) && (v_cnt_q == {VC_W{1'b0}});
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset to the idle/blank state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      h_cnt_q       <= {HC_W{1'b0}};
      v_cnt_q       <= {VC_W{1'b0}};
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_en_q    <= 1'b0;
      x_q           <= {X_W{1'b0}};
      y_q           <= {Y_W{1'b0}};
      addr_q        <= {ADDR_W{1'b0}};
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_en_q    <= video_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_en_o    = video_en_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign addr_o        = addr_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: a default-timing instance and a small
// instance with inverted hsync polarity share clock, reset and pixel enable,
// and both are compared every clock against a position-based reference model.
module tb_video_timing_generator;

  typedef struct {
    int h_act, h_fp, h_sy, h_bp;
    int v_act, v_fp, v_sy, v_bp;
    int hp, vp, sh;
  } cfg_t;

  typedef struct {
    int hs, vs, ve, x, y, addr, ls, fs;
  } obs_t;

  typedef struct {
    int n;      // enabled edges applied since reset release
    int en;     // pixel enable level used for those edges
    obs_t exp;  // expected default-instance outputs afterwards
  } vec_t;

  logic clk;
  logic rst_n;
  logic pixel_en;

  logic hsync_a, vsync_a, video_en_a, line_start_a, frame_start_a;
  logic [9:0]  x_a;
  logic [8:0]  y_a;
  logic [16:0] addr_a;

  logic hsync_b, vsync_b, video_en_b, line_start_b, frame_start_b;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic [4:0] addr_b;

  int vectors = 0;
  int errors  = 0;

  cfg_t ca, cb;
  int   pa, pb;   // linear raster position the model expects next
  obs_t ea, eb;   // model's expected outputs

  video_timing_generator dut_a (
    .clk_i(clk), .reset_ni(rst_n), .pixel_en_i(pixel_en),
    .hsync_o(hsync_a), .vsync_o(vsync_a), .video_en_o(video_en_a),
    .x_o(x_a), .y_o(y_a), .addr_o(addr_a),
    .line_start_o(line_start_a), .frame_start_o(frame_start_a)
  );

  video_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .SCALE_SHIFT(1)
  ) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .pixel_en_i(pixel_en),
    .hsync_o(hsync_b), .vsync_o(vsync_b), .video_en_o(video_en_b),
    .x_o(x_b), .y_o(y_b), .addr_o(addr_b),
    .line_start_o(line_start_b), .frame_start_o(frame_start_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int frame_len(cfg_t c);
    return (c.h_act + c.h_fp + c.h_sy + c.h_bp) * (c.v_act + c.v_fp + c.v_sy + c.v_bp);
  endfunction

  // Expected outputs one clock after an enabled edge at linear position p.
  function automatic obs_t decode(cfg_t c, int p);
    obs_t o;
    int ht, h, v;
    ht = c.h_act + c.h_fp + c.h_sy + c.h_bp;
    h  = p % ht;
    v  = p / ht;
    o.hs   = (h >= c.h_act + c.h_fp && h < c.h_act + c.h_fp + c.h_sy) ? c.hp : 1 - c.hp;
    o.vs   = (v >= c.v_act + c.v_fp && v < c.v_act + c.v_fp + c.v_sy) ? c.vp : 1 - c.vp;
    o.ve   = (h < c.h_act && v < c.v_act) ? 1 : 0;
    o.x    = o.ve ? h : 0;
    o.y    = o.ve ? v : 0;
    o.addr = o.ve ? (v >> c.sh) * (c.h_act >> c.sh) + (h >> c.sh) : 0;
    o.ls   = (h == 0) ? 1 : 0;
    o.fs   = (p == 0) ? 1 : 0;
    return o;
  endfunction

  function automatic obs_t rst_obs(cfg_t c);
    obs_t o;
    o.hs = 1 - c.hp; o.vs = 1 - c.vp; o.ve = 0;
    o.x = 0; o.y = 0; o.addr = 0; o.ls = 0; o.fs = 0;
    return o;
  endfunction

  function automatic obs_t get_a();
    obs_t o;
    o.hs = int'(hsync_a); o.vs = int'(vsync_a); o.ve = int'(video_en_a);
    o.x = int'(x_a); o.y = int'(y_a); o.addr = int'(addr_a);
    o.ls = int'(line_start_a); o.fs = int'(frame_start_a);
    return o;
  endfunction

  function automatic obs_t get_b();
    obs_t o;
    o.hs = int'(hsync_b); o.vs = int'(vsync_b); o.ve = int'(video_en_b);
    o.x = int'(x_b); o.y = int'(y_b); o.addr = int'(addr_b);
    o.ls = int'(line_start_b); o.fs = int'(frame_start_b);
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t act, input obs_t exp);
    check({tag, "_hsync"},    act.hs,   exp.hs);
    check({tag, "_vsync"},    act.vs,   exp.vs);
    check({tag, "_video_en"}, act.ve,   exp.ve);
    check({tag, "_x"},        act.x,    exp.x);
    check({tag, "_y"},        act.y,    exp.y);
    check({tag, "_addr"},     act.addr, exp.addr);
    check({tag, "_line_st"},  act.ls,   exp.ls);
    check({tag, "_frame_st"}, act.fs,   exp.fs);
  endtask

  // One clock: drive enable at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit en);
    @(negedge clk);
    pixel_en = en;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pa = 0; pb = 0;
      ea = rst_obs(ca); eb = rst_obs(cb);
    end else if (en) begin
      ea = decode(ca, pa); pa = (pa + 1) % frame_len(ca);
      eb = decode(cb, pb); pb = (pb + 1) % frame_len(cb);
    end else begin
      ea.ls = 0; ea.fs = 0;
      eb.ls = 0; eb.fs = 0;
    end
    check_obs("A", get_a(), ea);
    check_obs("B", get_b(), eb);
  endtask

  // Drop reset between clock edges (called just after a sampled edge), check
  // the outputs change before the next edge, hold for some clocks, release.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    pa = 0; pb = 0;
    ea = rst_obs(ca); eb = rst_obs(cb);
    check_obs("A_async_rst", get_a(), ea);
    check_obs("B_async_rst", get_b(), eb);
    for (int i = 0; i < hold; i++) step(1'b1);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[11];

  initial begin
    int n, low_cnt, first_low, ls1, ls2, fs1, fs2;

    ca = '{h_act:640, h_fp:16, h_sy:96, h_bp:48, v_act:480, v_fp:10, v_sy:2, v_bp:33,
           hp:0, vp:0, sh:1};
    cb = '{h_act:16, h_fp:2, h_sy:3, h_bp:3, v_act:8, v_fp:2, v_sy:2, v_bp:3,
           hp:1, vp:0, sh:1};

    //                 n     en   hs vs ve  x    y  addr ls fs
    tbl[0]  = '{1,    1, '{1, 1, 1, 0,   0, 0,   1, 1}};  // (0,0)
    tbl[1]  = '{641,  1, '{1, 1, 0, 0,   0, 0,   0, 0}};  // (640,0) blank
    tbl[2]  = '{656,  1, '{1, 1, 0, 0,   0, 0,   0, 0}};  // (655,0) last FP
    tbl[3]  = '{657,  1, '{0, 1, 0, 0,   0, 0,   0, 0}};  // (656,0) sync start
    tbl[4]  = '{752,  1, '{0, 1, 0, 0,   0, 0,   0, 0}};  // (751,0) sync end
    tbl[5]  = '{753,  1, '{1, 1, 0, 0,   0, 0,   0, 0}};  // (752,0) back porch
    tbl[6]  = '{800,  1, '{1, 1, 0, 0,   0, 0,   0, 0}};  // (799,0) last
    tbl[7]  = '{801,  1, '{1, 1, 1, 0,   1, 0,   1, 0}};  // (0,1)
    tbl[8]  = '{1440, 1, '{1, 1, 1, 639, 1, 319, 0, 0}};  // (639,1)
    tbl[9]  = '{1601, 1, '{1, 1, 1, 0,   2, 320, 1, 0}};  // (0,2)
    tbl[10] = '{2403, 1, '{1, 1, 1, 2,   3, 321, 0, 0}};  // (2,3)

    pixel_en = 1'b0;
    rst_n    = 1'b1;
    pa = 0; pb = 0;
    ea = rst_obs(ca); eb = rst_obs(cb);

    // Power-up reset, held for two clocks with the enable low.
    async_reset(0);
    step(1'b0);
    step(1'b0);
    #1;
    rst_n = 1'b1;

    // Table vectors on the default instance.
    n = 0;
    for (int i = 0; i < 11; i++) begin
      while (n < tbl[i].n) begin
        step(tbl[i].en != 0);
        n++;
      end
      check_obs($sformatf("tbl%0d", i), get_a(), tbl[i].exp);
    end

    // Default line: hsync width/position and line_start spacing.
    async_reset(2);
    low_cnt = 0; first_low = -1; ls1 = -1; ls2 = -1;
    for (int k = 1; k <= 1600; k++) begin
      step(1'b1);
      if (k <= 800 && hsync_a == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
      end
      if (line_start_a == 1'b1) begin
        if (ls1 < 0) ls1 = k;
        else if (ls2 < 0) ls2 = k;
      end
    end
    check("hsync_low_cycles", low_cnt, 96);
    check("hsync_first_low_edge", first_low, 657);
    check("line_start_gap", ls2 - ls1, 800);

    // Randomized enable with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 799) == 0) async_reset($urandom_range(1, 3));
    end

    // Mid-frame reset on the small instance, then restart from (0,0).
    for (int k = 0; k < 1000 && pb != 180; k++) step(1'b1);
    check("B_pre_reset_x", int'(x_b), 11);
    check("B_pre_reset_y", int'(y_b), 7);
    async_reset(1);
    step(1'b1);
    check("B_restart_frame_st", int'(frame_start_b), 1);
    check("B_restart_video_en", int'(video_en_b), 1);

    // Enable toggling 1,0: frame_start period is twice the frame length.
    async_reset(1);
    fs1 = -1; fs2 = -1;
    for (int c = 1; c <= 3000 && fs2 < 0; c++) begin
      step((c % 2) == 1);
      if (frame_start_b == 1'b1) begin
        if (fs1 < 0) fs1 = c;
        else fs2 = c;
      end
    end
    check("B_frame_start_period", fs2 - fs1, 2 * frame_len(cb));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
